// File: rtl/e203_rst_seq.sv
// e203_rst_seq: board-level reset sequencer driving the SoC external reset.
// Synchronises PLL lock and the reset button, debounces button presses,
// and holds the SoC in reset until lock is stable for a programmable stretch.
// Optional build macro: E203_RST_SEQ_LOCK_LOSS_RESET_EN. When it is defined,
// losing lock while running puts the SoC back into reset.
module e203_rst_seq #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYCLES  = 50000,
  parameter int unsigned RST_CYCLES  = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic       hfextclk,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       erstn,
  input  logic       clr_status,
  output logic       reset_n,
  output logic [1:0] seq_state,
  output logic       ext_rst_seen,
  output logic       lock_lost
);

  typedef enum logic [1:0] {
    S_HOLD      = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STRETCH   = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEB_CYCLES);
  localparam logic [CNT_W-1:0] STR_LAST = CNT_W'(RST_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_lock_sync;
  logic [SYNC_STAGES-1:0] r_erstn_sync;
  logic [CNT_W-1:0]       r_deb_cnt;
  logic [CNT_W-1:0]       r_str_cnt;
  state_t                 r_state;
  logic                   r_reset_n;
  logic                   r_ext_rst_seen;
  logic                   r_lock_lost;

  logic   w_lock_s;
  logic   w_erstn_s;
  logic   w_btn_held;
  state_t w_next;
  logic   w_set_ext;
  logic   w_set_lost;

  // Two-flop style synchronisers; the button chain resets to "released".
  always_ff @(posedge hfextclk) begin
    if (reset) begin
      r_lock_sync  <= '0;
      r_erstn_sync <= '1;
    end else begin
      r_lock_sync  <= {r_lock_sync[SYNC_STAGES-2:0], pll_lock};
      r_erstn_sync <= {r_erstn_sync[SYNC_STAGES-2:0], erstn};
    end
  end

  assign w_lock_s  = r_lock_sync[SYNC_STAGES-1];
  assign w_erstn_s = r_erstn_sync[SYNC_STAGES-1];

  // Debounce counter: counts low cycles, saturates, clears instantly on release.
  always_ff @(posedge hfextclk) begin
    if (reset) begin
      r_deb_cnt <= '0;
    end else if (w_erstn_s) begin
      r_deb_cnt <= '0;
    end else if (r_deb_cnt != DEB_MAX) begin
      r_deb_cnt <= r_deb_cnt + CNT_W'(1);
    end
  end

  assign w_btn_held = (r_deb_cnt == DEB_MAX);

  // Next-state and sticky-flag set conditions.
  always_comb begin
    w_next     = r_state;
    w_set_ext  = 1'b0;
    w_set_lost = 1'b0;
    case (r_state)
      S_HOLD: begin
        w_next = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (w_lock_s && !w_btn_held) begin
          w_next = S_STRETCH;
        end
      end
      S_STRETCH: begin
        if (w_btn_held || !w_lock_s) begin
          w_next = S_WAIT_LOCK;
        end else if (r_str_cnt == STR_LAST) begin
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        w_set_lost = !w_lock_s;
        if (w_btn_held) begin
          w_next    = S_WAIT_LOCK;
          w_set_ext = 1'b1;
        end else if (!w_lock_s) begin
`ifdef E203_RST_SEQ_LOCK_LOSS_RESET_EN
          w_next = S_WAIT_LOCK;
`else
          w_next = S_RUN;
`endif
        end
      end
      default: begin
        w_next = S_HOLD;
      end
    endcase
  end

  // State register; reset_n is registered from next state so it tracks S_RUN exactly.
  always_ff @(posedge hfextclk) begin
    if (reset) begin
      r_state   <= S_HOLD;
      r_reset_n <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_reset_n <= (w_next == S_RUN);
    end
  end

  // Stretch counter runs only while staying in S_STRETCH; any entry or abort restarts it.
  always_ff @(posedge hfextclk) begin
    if (reset) begin
      r_str_cnt <= '0;
    end else if (r_state == S_STRETCH && w_next == S_STRETCH) begin
      r_str_cnt <= r_str_cnt + CNT_W'(1);
    end else begin
      r_str_cnt <= '0;
    end
  end

  // Sticky status flags; a set in the same cycle as clr_status wins.
  always_ff @(posedge hfextclk) begin
    if (reset) begin
      r_ext_rst_seen <= 1'b0;
      r_lock_lost    <= 1'b0;
    end else begin
      if (w_set_ext) begin
        r_ext_rst_seen <= 1'b1;
      end else if (clr_status) begin
        r_ext_rst_seen <= 1'b0;
      end
      if (w_set_lost) begin
        r_lock_lost <= 1'b1;
      end else if (clr_status) begin
        r_lock_lost <= 1'b0;
      end
    end
  end

  assign reset_n      = r_reset_n;
  assign seq_state    = r_state;
  assign ext_rst_seen = r_ext_rst_seen;
  assign lock_lost    = r_lock_lost;

endmodule

// File: tb/tb_e203_rst_seq.sv
// Scoreboard bench for e203_rst_seq (SYNC_STAGES=2, DEB_CYCLES=8, RST_CYCLES=16).
// Expected outputs are queued per clock edge by the stimulus process and
// checked by an independent monitor shortly after each rising edge.
module tb_e203_rst_seq;

  logic       clk;
  logic       reset;
  logic       pll_lock;
  logic       erstn;
  logic       clr_status;
  logic       reset_n;
  logic [1:0] seq_state;
  logic       ext_rst_seen;
  logic       lock_lost;

  e203_rst_seq #(
    .SYNC_STAGES(2),
    .DEB_CYCLES (8),
    .RST_CYCLES (16),
    .CNT_W      (16)
  ) dut (
    .hfextclk    (clk),
    .reset       (reset),
    .pll_lock    (pll_lock),
    .erstn       (erstn),
    .clr_status  (clr_status),
    .reset_n     (reset_n),
    .seq_state   (seq_state),
    .ext_rst_seen(ext_rst_seen),
    .lock_lost   (lock_lost)
  );

  typedef struct {
    int         e;
    string      nm;
    logic [1:0] st;
    logic       rn;
    logic       ext;
    logic       lost;
  } exp_t;

  exp_t sb[$];
  exp_t it;
  int   edge_n = 0;
  int   base   = 0;
  int   n_cmp  = 0;
  int   n_mis  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Expect outputs (state, reset_n, ext_rst_seen, lock_lost) right after edge base+k.
  task automatic ex(input int k, input string nm, input logic [1:0] st,
                    input logic rn, input logic ext, input logic lost);
    exp_t x;
    x.e = base + k; x.nm = nm; x.st = st; x.rn = rn; x.ext = ext; x.lost = lost;
    sb.push_back(x);
  endtask

  // Return at the falling edge following edge base+k.
  task automatic wait_to(input int k);
    while (edge_n < base + k) @(negedge clk);
  endtask

  // Monitor: compare every queued expectation that has come due.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      while (sb.size() != 0 && sb[0].e <= edge_n) begin
        it = sb.pop_front();
        n_cmp++;
        if (it.e != edge_n || seq_state !== it.st || reset_n !== it.rn ||
            ext_rst_seen !== it.ext || lock_lost !== it.lost) begin
          n_mis++;
          $display("FAIL %s edge=%0d due=%0d: got st=%0d rn=%b ext=%b lost=%b, want st=%0d rn=%b ext=%b lost=%b",
                   it.nm, edge_n, it.e, seq_state, reset_n, ext_rst_seen, lock_lost,
                   it.st, it.rn, it.ext, it.lost);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; pll_lock = 1'b1; erstn = 1'b1; clr_status = 1'b0;

    // Reset state and power-up sequence.
    base = 0;
    ex(1, "rst_e1", 2'd0, 1'b0, 1'b0, 1'b0);
    ex(3, "rst_e3", 2'd0, 1'b0, 1'b0, 1'b0);
    wait_to(3);
    reset = 1'b0;
    base = edge_n;
    ex(1,  "pu_wait1",   2'd1, 1'b0, 1'b0, 1'b0);
    ex(2,  "pu_wait2",   2'd1, 1'b0, 1'b0, 1'b0);
    ex(3,  "pu_stretch", 2'd2, 1'b0, 1'b0, 1'b0);
    ex(18, "pu_pre_run", 2'd2, 1'b0, 1'b0, 1'b0);
    ex(19, "pu_run",     2'd3, 1'b1, 1'b0, 1'b0);
    ex(20, "pu_run2",    2'd3, 1'b1, 1'b0, 1'b0);
    wait_to(20);
    n_cmp++;
    if (reset_n !== 1'b1) begin
      n_mis++;
      $display("FAIL direct pu_reset_n: got %b want 1", reset_n);
    end
    n_cmp++;
    if (seq_state !== 2'd3) begin
      n_mis++;
      $display("FAIL direct pu_state: got %0d want 3", seq_state);
    end

    // Glitch: 7 low samples never reach DEB_CYCLES.
    base = edge_n;
    ex(11, "glitch_a", 2'd3, 1'b1, 1'b0, 1'b0);
    ex(15, "glitch_b", 2'd3, 1'b1, 1'b0, 1'b0);
    erstn = 1'b0;
    wait_to(7);
    erstn = 1'b1;
    wait_to(15);
    n_cmp++;
    if (reset_n !== 1'b1) begin
      n_mis++;
      $display("FAIL direct glitch_reset_n: got %b want 1", reset_n);
    end
    n_cmp++;
    if (ext_rst_seen !== 1'b0) begin
      n_mis++;
      $display("FAIL direct glitch_ext: got %b want 0", ext_rst_seen);
    end

    // Real press: 20 low samples, then release and full re-stretch.
    base = edge_n;
    ex(10, "press_pre",  2'd3, 1'b1, 1'b0, 1'b0);
    ex(11, "press_fall", 2'd1, 1'b0, 1'b1, 1'b0);
    ex(20, "press_held", 2'd1, 1'b0, 1'b1, 1'b0);
    ex(39, "rel_pre",    2'd2, 1'b0, 1'b1, 1'b0);
    ex(40, "rel_run",    2'd3, 1'b1, 1'b1, 1'b0);
    erstn = 1'b0;
    wait_to(20);
    erstn = 1'b1;
    wait_to(40);
    n_cmp++;
    if (ext_rst_seen !== 1'b1) begin
      n_mis++;
      $display("FAIL direct press_ext: got %b want 1", ext_rst_seen);
    end

    // clr_status clears ext_rst_seen.
    base = edge_n;
    ex(1, "clr_ext", 2'd3, 1'b1, 1'b0, 1'b0);
    clr_status = 1'b1;
    wait_to(1);
    clr_status = 1'b0;

    // Stretch abort: reset to restart, drop lock when stretch_cnt reaches 10.
    base = edge_n;
    ex(1, "abort_rst", 2'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    wait_to(1);
    reset = 1'b0;
    base = edge_n;
    ex(1,  "abort_w1",   2'd1, 1'b0, 1'b0, 1'b0);
    ex(3,  "abort_s0",   2'd2, 1'b0, 1'b0, 1'b0);
    ex(13, "abort_s10",  2'd2, 1'b0, 1'b0, 1'b0);
    ex(14, "abort_back", 2'd1, 1'b0, 1'b0, 1'b0);
    ex(16, "abort_wait", 2'd1, 1'b0, 1'b0, 1'b0);
    ex(17, "abort_re_s", 2'd2, 1'b0, 1'b0, 1'b0);
    ex(32, "abort_pre",  2'd2, 1'b0, 1'b0, 1'b0);
    ex(33, "abort_run",  2'd3, 1'b1, 1'b0, 1'b0);
    wait_to(11);
    pll_lock = 1'b0;
    wait_to(14);
    pll_lock = 1'b1;
    wait_to(33);

    // Lock loss in S_RUN for 5 samples.
    base = edge_n;
    ex(2, "ll_pre", 2'd3, 1'b1, 1'b0, 1'b0);
`ifdef E203_RST_SEQ_LOCK_LOSS_RESET_EN
    ex(3,  "ll_drop",  2'd1, 1'b0, 1'b0, 1'b1);
    ex(7,  "ll_wait",  2'd1, 1'b0, 1'b0, 1'b1);
    ex(8,  "ll_str",   2'd2, 1'b0, 1'b0, 1'b1);
    ex(23, "ll_pre_r", 2'd2, 1'b0, 1'b0, 1'b1);
    ex(24, "ll_run",   2'd3, 1'b1, 1'b0, 1'b1);
`else
    ex(3,  "ll_drop",  2'd3, 1'b1, 1'b0, 1'b1);
    ex(7,  "ll_wait",  2'd3, 1'b1, 1'b0, 1'b1);
    ex(8,  "ll_str",   2'd3, 1'b1, 1'b0, 1'b1);
    ex(23, "ll_pre_r", 2'd3, 1'b1, 1'b0, 1'b1);
    ex(24, "ll_run",   2'd3, 1'b1, 1'b0, 1'b1);
`endif
    pll_lock = 1'b0;
    wait_to(5);
    pll_lock = 1'b1;
    wait_to(24);
    n_cmp++;
    if (lock_lost !== 1'b1) begin
      n_mis++;
      $display("FAIL direct ll_lost: got %b want 1", lock_lost);
    end

    // clr_status clears lock_lost, then coincides with a new press.
    base = edge_n;
    ex(1, "clr_lost", 2'd3, 1'b1, 1'b0, 1'b0);
    clr_status = 1'b1;
    wait_to(1);
    clr_status = 1'b0;
    base = edge_n;
    ex(10, "pr2_pre",     2'd3, 1'b1, 1'b0, 1'b0);
    ex(11, "pr2_set_win", 2'd1, 1'b0, 1'b1, 1'b0);
    ex(12, "pr2_sticky",  2'd1, 1'b0, 1'b1, 1'b0);
    ex(30, "pr2_pre_run", 2'd2, 1'b0, 1'b1, 1'b0);
    ex(31, "pr2_run",     2'd3, 1'b1, 1'b1, 1'b0);
    erstn = 1'b0;
    wait_to(10);
    clr_status = 1'b1;
    wait_to(11);
    clr_status = 1'b0;
    erstn = 1'b1;
    wait_to(31);

    // Mid-sequence reset while in S_STRETCH.
    base = edge_n;
    ex(11, "mr_wait",   2'd1, 1'b0, 1'b1, 1'b0);
    ex(14, "mr_str",    2'd2, 1'b0, 1'b1, 1'b0);
    ex(19, "mr_str5",   2'd2, 1'b0, 1'b1, 1'b0);
    ex(20, "mr_reset",  2'd0, 1'b0, 1'b0, 1'b0);
    ex(21, "mr_wait2",  2'd1, 1'b0, 1'b0, 1'b0);
    ex(23, "mr_str2",   2'd2, 1'b0, 1'b0, 1'b0);
    ex(38, "mr_pre_run",2'd2, 1'b0, 1'b0, 1'b0);
    ex(39, "mr_run",    2'd3, 1'b1, 1'b0, 1'b0);
    erstn = 1'b0;
    wait_to(10);
    erstn = 1'b1;
    wait_to(19);
    reset = 1'b1;
    wait_to(20);
    reset = 1'b0;
    wait_to(39);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      n_cmp++;
      n_mis++;
      $display("FAIL %s: never checked, got none, want edge %0d", it.nm, it.e);
    end

    if (n_cmp < 12) begin
      $display("FAIL too few comparisons: %0d", n_cmp);
    end
    if (n_mis != 0) begin
      $display("FAIL %0d mismatches", n_mis);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
